// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: state encodings and defaults shared by the hazard controller slice
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    HZ_RUN         = 2'd0,
    HZ_LOAD_BUBBLE = 2'd1,
    HZ_MULDIV_WAIT = 2'd2
  } hz_state_t;
  localparam int MULDIV_TIMEOUT_DEF = 64;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX hazard inputs and pipeline stall/flush controls
interface hazard_ctrl_if;
  logic [4:0]  rs1_IF_ID_in;
  logic [4:0]  rs2_IF_ID_in;
  logic [4:0]  rd_ID_EX_in;
  logic        mem_read_ID_EX_signal_in;
  logic        muldiv_ID_EX_signal_in;
  logic        muldiv_done_signal_in;
  logic        branch_taken_EX_signal_in;
  logic        dmem_busy_signal_in;
  logic        pc_stall_signal_out;
  logic        IF_ID_stall_signal_out;
  logic        IF_ID_flush_signal_out;
  logic        ID_EX_stall_signal_out;
  logic        ID_EX_flush_signal_out;
  logic        EX_MEM_stall_signal_out;
  logic        muldiv_start_signal_out;
  logic        muldiv_timeout_signal_out;
  logic [31:0] stall_count_out;
  modport master (
    output rs1_IF_ID_in, rs2_IF_ID_in, rd_ID_EX_in, mem_read_ID_EX_signal_in,
           muldiv_ID_EX_signal_in, muldiv_done_signal_in, branch_taken_EX_signal_in,
           dmem_busy_signal_in,
    input  pc_stall_signal_out, IF_ID_stall_signal_out, IF_ID_flush_signal_out,
           ID_EX_stall_signal_out, ID_EX_flush_signal_out, EX_MEM_stall_signal_out,
           muldiv_start_signal_out, muldiv_timeout_signal_out, stall_count_out
  );
  modport slave (
    input  rs1_IF_ID_in, rs2_IF_ID_in, rd_ID_EX_in, mem_read_ID_EX_signal_in,
           muldiv_ID_EX_signal_in, muldiv_done_signal_in, branch_taken_EX_signal_in,
           dmem_busy_signal_in,
    output pc_stall_signal_out, IF_ID_stall_signal_out, IF_ID_flush_signal_out,
           ID_EX_stall_signal_out, ID_EX_flush_signal_out, EX_MEM_stall_signal_out,
           muldiv_start_signal_out, muldiv_timeout_signal_out, stall_count_out
  );
endinterface

// File: rtl/hazard_ctrl_perf_counter.sv
// hazard_perf_counter: 32-bit saturating event counter with enable
module hazard_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (en && count != '1) count <= count + 32'd1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, MUL/DIV, dmem-wait and branch stall/flush control; HAZARD_CTRL_PERF_EN adds a stall counter
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_TIMEOUT = MULDIV_TIMEOUT_DEF
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);
  hz_state_t st, nxt;
  logic [7:0] cnt;
  logic to_flag, lu, stall_all, lu_stall, br_flush, start, to_set;
  assign lu = hz.mem_read_ID_EX_signal_in && hz.rd_ID_EX_in != 5'd0 &&
              (hz.rd_ID_EX_in == hz.rs1_IF_ID_in || hz.rd_ID_EX_in == hz.rs2_IF_ID_in);
  always_comb begin
    nxt = st;
    stall_all = 1'b0;
    lu_stall = 1'b0;
    br_flush = 1'b0;
    start = 1'b0;
    to_set = 1'b0;
    if (hz.dmem_busy_signal_in) stall_all = 1'b1;
    else case (st)
      HZ_RUN: begin
        if (hz.muldiv_ID_EX_signal_in) begin
          start = 1'b1;
          stall_all = 1'b1;
          nxt = HZ_MULDIV_WAIT;
        end else if (hz.branch_taken_EX_signal_in) br_flush = 1'b1;
        else if (lu) begin
          lu_stall = 1'b1;
          nxt = HZ_LOAD_BUBBLE;
        end
      end
      HZ_LOAD_BUBBLE: nxt = HZ_RUN;
      HZ_MULDIV_WAIT: begin
        // done or abort both release the pipe so the MUL/DIV leaves EX this cycle
        if (hz.muldiv_done_signal_in) nxt = HZ_RUN;
        else if (cnt == 8'(MULDIV_TIMEOUT - 1)) begin
          to_set = 1'b1;
          nxt = HZ_RUN;
        end else stall_all = 1'b1;
      end
      default: nxt = HZ_RUN;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= HZ_RUN;
      cnt <= '0;
      to_flag <= 1'b0;
    end else begin
      st <= nxt;
      if (start) cnt <= '0;
      else if (st == HZ_MULDIV_WAIT && !hz.dmem_busy_signal_in && cnt != 8'hFF) cnt <= cnt + 8'd1;
      if (to_set) to_flag <= 1'b1;
    end
  assign hz.pc_stall_signal_out       = stall_all | lu_stall;
  assign hz.IF_ID_stall_signal_out    = stall_all | lu_stall;
  assign hz.IF_ID_flush_signal_out    = br_flush;
  assign hz.ID_EX_stall_signal_out    = stall_all;
  assign hz.ID_EX_flush_signal_out    = br_flush | lu_stall;
  assign hz.EX_MEM_stall_signal_out   = stall_all;
  assign hz.muldiv_start_signal_out   = start;
  assign hz.muldiv_timeout_signal_out = to_flag;
`ifdef HAZARD_CTRL_PERF_EN
  hazard_perf_counter u_perf (
    .clk  (clk),
    .rst  (rst),
    .en   (hz.pc_stall_signal_out),
    .count(hz.stall_count_out)
  );
`else
  assign hz.stall_count_out = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl with MULDIV_TIMEOUT = 8
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  hazard_ctrl_if hz();
  hazard_ctrl #(.MULDIV_TIMEOUT(8)) dut (.clk(clk), .rst(rst), .hz(hz));
  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_cnt = '0;
  // {pc_st, ifid_st, ifid_fl, idex_st, idex_fl, exmem_st, start, timeout}
  localparam logic [7:0] IDLE  = 8'b0000_0000;
  localparam logic [7:0] LU    = 8'b1100_1000;
  localparam logic [7:0] BR    = 8'b0010_1000;
  localparam logic [7:0] ALL4  = 8'b1101_0100;
  localparam logic [7:0] START = 8'b1101_0110;
  logic [7:0] obs;
  assign obs = {hz.pc_stall_signal_out, hz.IF_ID_stall_signal_out, hz.IF_ID_flush_signal_out,
                hz.ID_EX_stall_signal_out, hz.ID_EX_flush_signal_out, hz.EX_MEM_stall_signal_out,
                hz.muldiv_start_signal_out, hz.muldiv_timeout_signal_out};
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic md, input logic dn, input logic br, input logic busy);
    hz.rs1_IF_ID_in = rs1;
    hz.rs2_IF_ID_in = rs2;
    hz.rd_ID_EX_in = rd;
    hz.mem_read_ID_EX_signal_in = mr;
    hz.muldiv_ID_EX_signal_in = md;
    hz.muldiv_done_signal_in = dn;
    hz.branch_taken_EX_signal_in = br;
    hz.dmem_busy_signal_in = busy;
  endtask
  task automatic step(input string tag, input logic [7:0] e);
    exp_t x;
    exp_t y;
    logic [31:0] cnt_req;
    x.tag = tag;
    x.v = e;
    q.push_back(x);
    #3;
    y = q.pop_front();
    if (rst) exp_cnt = '0;
`ifdef HAZARD_CTRL_PERF_EN
    cnt_req = exp_cnt;
`else
    cnt_req = 32'd0;
`endif
    n_cmp++;
    assert (obs === y.v)
      else begin
        n_err++;
        $error("FAIL %s: observed %b expected %b", y.tag, obs, y.v);
      end
    n_cmp++;
    assert (hz.stall_count_out === cnt_req)
      else begin
        n_err++;
        $error("FAIL %s_count: observed %0d expected %0d", y.tag, hz.stall_count_out, cnt_req);
      end
    if (!rst && y.v[7]) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    step("rst_state", IDLE);
    rst = 1'b0;
    drive(5, 0, 5, 1, 0, 0, 0, 0);
    step("lu_rs1", LU);
    step("lu_bubble", IDLE);
    drive(5, 0, 5, 0, 0, 0, 0, 0);
    step("run_idle", IDLE);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    step("lu_rd0", IDLE);
    drive(3, 7, 7, 1, 0, 0, 0, 0);
    step("lu_rs2", LU);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("lu_rs2_bubble", IDLE);
    drive(5, 0, 5, 1, 0, 0, 1, 0);
    step("br_over_lu", BR);
    drive(5, 0, 5, 1, 0, 0, 0, 0);
    step("br_stays_run", LU);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("br_bubble", IDLE);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    step("mul_start", START);
    for (int i = 1; i <= 4; i++) step($sformatf("mul_wait%0d", i), ALL4);
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    step("mul_done_no_restart", IDLE);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    step("done_in_run", IDLE);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    step("to_start", START);
    step("to_wait0", ALL4);
    drive(0, 0, 0, 0, 1, 0, 0, 1);
    step("busy0", ALL4);
    drive(0, 0, 0, 0, 1, 1, 0, 1);
    step("busy1_done_ignored", ALL4);
    drive(0, 0, 0, 0, 1, 0, 0, 1);
    step("busy2", ALL4);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 6; i++) step($sformatf("to_wait%0d", i), ALL4);
    step("to_abort", IDLE);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("to_flag", 8'h01);
    step("to_sticky", 8'h01);
    drive(5, 0, 5, 1, 0, 0, 0, 0);
    step("lu_with_flag", LU | 8'h01);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("bubble_with_flag", 8'h01);
    drive(0, 0, 0, 0, 1, 0, 0, 1);
    step("busy_defers_start", ALL4 | 8'h01);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    step("start_after_busy", START | 8'h01);
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    step("done2", 8'h01);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("idle_flag", 8'h01);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    step("rst_pre_start", START | 8'h01);
    step("rst_pre_wait", ALL4 | 8'h01);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("rst_mid_wait", IDLE);
    rst = 1'b0;
    step("after_rst", IDLE);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
